// File: rtl/periph_timer_bus.sv
`default_nettype none
//============================================================================
// Module      : periph_timer_bus
// Description : Memory-mapped peripheral slave on the CPU load/store port.
//               Holds a reload timer (TH/TL/TCON), an LED register, a
//               switch input port and a 7-segment digit register. The
//               timer overflow raises a level interrupt on irqout.
//               Optional macro PERIPH_SWITCH_SYNC_EN: when defined, the
//               switch inputs pass through a 2-flop synchronizer before
//               reaching the read path; when undefined they are read
//               combinationally.
// Revision    : 1.0 - initial release
//============================================================================
module periph_timer_bus #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned LED_W     = 8,
    parameter int unsigned SW_W      = 8,
    parameter int unsigned DIGI_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [LED_W-1:0]  led,
    input  logic [SW_W-1:0]   switch,
    output logic [DIGI_W-1:0] digi,
    output logic              irqout
);

    // Word indices of the registers inside the window
    localparam logic [2:0] c_IDX_TH   = 3'd0;
    localparam logic [2:0] c_IDX_TL   = 3'd1;
    localparam logic [2:0] c_IDX_TCON = 3'd2;
    localparam logic [2:0] c_IDX_LED  = 3'd3;
    localparam logic [2:0] c_IDX_SW   = 3'd4;
    localparam logic [2:0] c_IDX_DIGI = 3'd5;

    // TCON bit positions
    localparam int unsigned c_TCON_EN  = 0;
    localparam int unsigned c_TCON_IE  = 1;
    localparam int unsigned c_TCON_IRQ = 2;

    localparam logic [31:0] c_TL_MAX = 32'hFFFF_FFFF;

    //------------------------------------------------------------------------
    // Address decode. Byte offset bits are ignored, so the offset is
    // computed on word addresses only.
    //------------------------------------------------------------------------
    logic [29:0] w_word_off;
    logic        w_in_window;
    logic [2:0]  w_idx;
    logic        w_unused_addr_bits;

    assign w_word_off         = addr[31:2] - BASE_ADDR[31:2];
    assign w_in_window        = (w_word_off[29:3] == 27'd0);
    assign w_idx              = w_word_off[2:0];
    assign w_unused_addr_bits = ^addr[1:0];

    logic w_wr_th;
    logic w_wr_tl;
    logic w_wr_tcon;
    logic w_wr_led;
    logic w_wr_digi;

    assign w_wr_th   = wr && w_in_window && (w_idx == c_IDX_TH);
    assign w_wr_tl   = wr && w_in_window && (w_idx == c_IDX_TL);
    assign w_wr_tcon = wr && w_in_window && (w_idx == c_IDX_TCON);
    assign w_wr_led  = wr && w_in_window && (w_idx == c_IDX_LED);
    assign w_wr_digi = wr && w_in_window && (w_idx == c_IDX_DIGI);

    //------------------------------------------------------------------------
    // Register state
    //------------------------------------------------------------------------
    logic [31:0]       th_q,   th_d;
    logic [31:0]       tl_q,   tl_d;
    logic [2:0]        tcon_q, tcon_d;
    logic [LED_W-1:0]  led_q,  led_d;
    logic [DIGI_W-1:0] digi_q, digi_d;

    //------------------------------------------------------------------------
    // Switch input path
    //------------------------------------------------------------------------
    logic [SW_W-1:0] w_switch;

`ifdef PERIPH_SWITCH_SYNC_EN
    logic [SW_W-1:0] sw_meta_q;
    logic [SW_W-1:0] sw_sync_q;

    // Two-stage synchronizer for the asynchronous board switches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign w_switch = sw_sync_q;
`else
    assign w_switch = switch;
`endif

    //------------------------------------------------------------------------
    // Next-state: timer advance first, CPU writes applied afterwards so a
    // write to TL or TCON in the overflow cycle overrides the timer's own
    // update. TH writes only affect th_d, so a reload in the same cycle
    // still uses the old TH.
    //------------------------------------------------------------------------
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        led_d  = led_q;
        digi_d = digi_q;

        if (tcon_q[c_TCON_EN]) begin
            if (tl_q != c_TL_MAX) begin
                tl_d = tl_q + 32'd1;
            end else begin
                tl_d = th_q;
                if (tcon_q[c_TCON_IE]) begin
                    tcon_d[c_TCON_IRQ] = 1'b1;
                end
            end
        end

        if (w_wr_th) begin
            th_d = wdata;
        end
        if (w_wr_tl) begin
            tl_d = wdata;
        end
        if (w_wr_tcon) begin
            tcon_d = wdata[2:0];
        end
        if (w_wr_led) begin
            led_d = wdata[LED_W-1:0];
        end
        if (w_wr_digi) begin
            digi_d = wdata[DIGI_W-1:0];
        end
    end

    // Register update with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            led_q  <= '0;
            digi_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            led_q  <= led_d;
            digi_q <= digi_d;
        end
    end

    //------------------------------------------------------------------------
    // Read mux: combinational from addr, zero when idle or unmapped
    //------------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        if (rd && w_in_window) begin
            case (w_idx)
                c_IDX_TH:   rdata = th_q;
                c_IDX_TL:   rdata = tl_q;
                c_IDX_TCON: rdata[2:0] = tcon_q;
                c_IDX_LED:  rdata[LED_W-1:0] = led_q;
                c_IDX_SW:   rdata[SW_W-1:0] = w_switch;
                c_IDX_DIGI: rdata[DIGI_W-1:0] = digi_q;
                default:    rdata = '0;
            endcase
        end
    end

    assign led    = led_q;
    assign digi   = digi_q;
    assign irqout = tcon_q[c_TCON_IE] & tcon_q[c_TCON_IRQ];

endmodule
`default_nettype wire

// File: tb/tb_periph_timer_bus.sv
`default_nettype none
//============================================================================
// Module      : tb_periph_timer_bus
// Description : Directed bench for periph_timer_bus: a vector table for the
//               register window and hand-written timer/reset sequences.
//               Honours PERIPH_SWITCH_SYNC_EN for the switch latency case.
// Revision    : 1.0 - initial release
//============================================================================
module tb_periph_timer_bus;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] O_TH = 32'h00, O_TL = 32'h04, O_TCON = 32'h08;
    localparam logic [31:0] O_SW = 32'h10;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic [7:0]  led;
    logic [7:0]  sw;
    logic [11:0] digi;
    logic        irqout;

    int checks   = 0;
    int failures = 0;

    periph_timer_bus #(
        .BASE_ADDR (BASE),
        .LED_W     (8),
        .SW_W      (8),
        .DIGI_W    (12)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .led    (led),
        .switch (sw),
        .digi   (digi),
        .irqout (irqout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_led;
        logic [11:0] exp_digi;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Single-cycle register write, returns 1 time unit after the edge
    task automatic wr_reg(input logic [31:0] off, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; rd = 1'b0; addr = BASE + off; wdata = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    // Combinational read check, consumes 1 time unit
    task automatic rd_chk(input string nm, input logic [31:0] off, input logic [31:0] exp);
        rd = 1'b1; addr = BASE + off;
        #1;
        chk(nm, rdata, exp);
        rd = 1'b0;
    endtask

    initial begin
        int cnt;

        vecs[0]  = '{1'b0, 1'b1, 32'h4000_000C, 32'h0000_00A5, 32'h0,         8'hA5, 12'h000};
        vecs[1]  = '{1'b0, 1'b1, 32'h4000_0014, 32'h0000_0FFF, 32'h0,         8'hA5, 12'hFFF};
        vecs[2]  = '{1'b1, 1'b0, 32'h4000_000C, 32'h0,         32'h0000_00A5, 8'hA5, 12'hFFF};
        vecs[3]  = '{1'b1, 1'b0, 32'h4000_0014, 32'h0,         32'h0000_0FFF, 8'hA5, 12'hFFF};
        vecs[4]  = '{1'b1, 1'b0, 32'h4000_0010, 32'h0,         32'h0000_003C, 8'hA5, 12'hFFF};
        vecs[5]  = '{1'b1, 1'b0, 32'h4000_0018, 32'h0,         32'h0,         8'hA5, 12'hFFF};
        vecs[6]  = '{1'b0, 1'b1, 32'h4000_0010, 32'h0000_0055, 32'h0,         8'hA5, 12'hFFF};
        vecs[7]  = '{1'b1, 1'b0, 32'h4000_0010, 32'h0,         32'h0000_003C, 8'hA5, 12'hFFF};
        vecs[8]  = '{1'b1, 1'b1, 32'h4000_000C, 32'h0000_005A, 32'h0000_00A5, 8'h5A, 12'hFFF};
        vecs[9]  = '{1'b1, 1'b1, 32'h3000_000C, 32'h0000_0011, 32'h0,         8'h5A, 12'hFFF};
        vecs[10] = '{1'b0, 1'b0, 32'h4000_000C, 32'h0,         32'h0,         8'h5A, 12'hFFF};
        vecs[11] = '{1'b1, 1'b0, 32'h4000_000F, 32'h0,         32'h0000_005A, 8'h5A, 12'hFFF};
        vecs[12] = '{1'b1, 1'b0, 32'h4000_0008, 32'h0,         32'h0,         8'h5A, 12'hFFF};
        vecs[13] = '{1'b1, 1'b1, 32'h4000_0000, 32'h1234_5678, 32'h0,         8'h5A, 12'hFFF};
        vecs[14] = '{1'b1, 1'b0, 32'h4000_0000, 32'h0,         32'h1234_5678, 8'h5A, 12'hFFF};
        vecs[15] = '{1'b1, 1'b0, 32'h4000_0020, 32'h0,         32'h0,         8'h5A, 12'hFFF};
        vecs[16] = '{1'b1, 1'b1, 32'h4000_0014, 32'hFFFF_F123, 32'h0000_0FFF, 8'h5A, 12'h123};
        vecs[17] = '{1'b1, 1'b0, 32'h3FFF_FFFC, 32'h0,         32'h0,         8'h5A, 12'h123};

        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; sw = 8'h00;

        // Reset state
        #2;
        chk("reset_led", {24'h0, led}, 32'h0);
        chk("reset_digi", {20'h0, digi}, 32'h0);
        chk("reset_irq", {31'h0, irqout}, 32'h0);
        rd_chk("reset_tl", O_TL, 32'h0);
        rd_chk("reset_tcon", O_TCON, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Register window vectors
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rd = vecs[i].rd; wr = vecs[i].wr; addr = vecs[i].addr; wdata = vecs[i].wdata;
            sw = 8'h3C;
            #1;
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_led", i), {24'h0, led}, {24'h0, vecs[i].exp_led});
            chk($sformatf("vec%0d_digi", i), {20'h0, digi}, {20'h0, vecs[i].exp_digi});
            rd = 1'b0; wr = 1'b0;
        end

        // Periodic interrupt: reload then 50001 edges to the next overflow
        wr_reg(O_TH, 32'hFFFF_3CAF);
        wr_reg(O_TL, 32'hFFFF_FFFF);
        wr_reg(O_TCON, 32'h3);
        @(posedge clk); #1;
        rd_chk("per_reload_tl", O_TL, 32'hFFFF_3CAF);
        rd_chk("per_reload_tcon", O_TCON, 32'h7);
        chk("per_irq_set", {31'h0, irqout}, 32'h1);
        wr_reg(O_TCON, 32'h3);
        chk("per_irq_clr", {31'h0, irqout}, 32'h0);
        cnt = 1;
        while (!irqout && cnt < 60000) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("per_period", cnt, 50001);
        rd_chk("per_tl2", O_TL, 32'hFFFF_3CAF);

        // Overflow coinciding with TL write
        wr_reg(O_TCON, 32'h0);
        wr_reg(O_TH, 32'h100);
        wr_reg(O_TL, 32'hFFFF_FFFE);
        wr_reg(O_TCON, 32'h3);
        @(posedge clk); #1;
        wr_reg(O_TL, 32'h5);
        rd_chk("col_tl_tl", O_TL, 32'h5);
        rd_chk("col_tl_tcon", O_TCON, 32'h7);
        chk("col_tl_irq", {31'h0, irqout}, 32'h1);

        // Overflow coinciding with TCON write
        wr_reg(O_TCON, 32'h0);
        wr_reg(O_TL, 32'hFFFF_FFFF);
        wr_reg(O_TCON, 32'h3);
        wr_reg(O_TCON, 32'h1);
        rd_chk("col_tcon_tcon", O_TCON, 32'h1);
        rd_chk("col_tcon_tl", O_TL, 32'h100);
        chk("col_tcon_irq", {31'h0, irqout}, 32'h0);

        // TH write in the reload cycle: reload takes the old TH
        wr_reg(O_TCON, 32'h0);
        wr_reg(O_TL, 32'hFFFF_FFFF);
        wr_reg(O_TCON, 32'h1);
        wr_reg(O_TH, 32'h200);
        rd_chk("th_same_tl", O_TL, 32'h100);
        rd_chk("th_same_th", O_TH, 32'h200);

        // Masked interrupt
        wr_reg(O_TCON, 32'h0);
        wr_reg(O_TL, 32'hFFFF_FFFE);
        wr_reg(O_TCON, 32'h1);
        @(posedge clk); #1;
        rd_chk("mask_tl1", O_TL, 32'hFFFF_FFFF);
        chk("mask_irq1", {31'h0, irqout}, 32'h0);
        @(posedge clk); #1;
        rd_chk("mask_tl2", O_TL, 32'h200);
        rd_chk("mask_tcon", O_TCON, 32'h1);
        chk("mask_irq2", {31'h0, irqout}, 32'h0);

        // TH = all ones: every enabled edge overflows
        wr_reg(O_TCON, 32'h0);
        wr_reg(O_TH, 32'hFFFF_FFFF);
        wr_reg(O_TL, 32'hFFFF_FFFF);
        wr_reg(O_TCON, 32'h3);
        @(posedge clk); #1;
        rd_chk("thmax_tl1", O_TL, 32'hFFFF_FFFF);
        rd_chk("thmax_tcon", O_TCON, 32'h7);
        @(posedge clk); #1;
        rd_chk("thmax_tl2", O_TL, 32'hFFFF_FFFF);
        chk("thmax_irq", {31'h0, irqout}, 32'h1);

        // Asynchronous reset between edges, counter frozen afterwards
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("arst_irq", {31'h0, irqout}, 32'h0);
        chk("arst_led", {24'h0, led}, 32'h0);
        chk("arst_digi", {20'h0, digi}, 32'h0);
        rd_chk("arst_tl", O_TL, 32'h0);
        sw = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd_chk("arst_tl_frozen", O_TL, 32'h0);
        rd_chk("arst_tcon", O_TCON, 32'h0);

        // Switch read latency
        @(negedge clk);
        sw = 8'hFF;
        rd_chk("sw_lat0", O_SW,
`ifdef PERIPH_SWITCH_SYNC_EN
            32'h00
`else
            32'hFF
`endif
        );
        @(posedge clk); #1;
        rd_chk("sw_lat1", O_SW,
`ifdef PERIPH_SWITCH_SYNC_EN
            32'h00
`else
            32'hFF
`endif
        );
        @(posedge clk); #1;
        rd_chk("sw_lat2", O_SW, 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
